// File: rtl/guess_commit_ctrl_pkg.sv
// Shared types and board geometry for committing one guess to board RAM.
package guess_commit_ctrl_pkg;

    localparam int unsigned max_pins_count   = 20;
    localparam int unsigned max_guesses      = 99;
    localparam int unsigned PIN_COLOR_W      = 5;
    localparam int unsigned PIN_POS_W        = 5;
    localparam int unsigned board_addr_w     = 12;
    localparam int unsigned ram_hints_offset = 1980;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GREEN,
        ST_YELLOW,
        ST_HINT_G,
        ST_HINT_Y,
        ST_DONE
    } GUESS_COMMIT_STATE;

    typedef enum logic [1:0] {
        SCAN_HOLD,
        SCAN_GREEN,
        SCAN_YELLOW
    } scan_phase_t;

endpackage

// File: rtl/pin_match_scan.sv
// Pin-by-pin green/yellow scan: owns the i/j counters, analyzed masks and hint counters.
module pin_match_scan
    import guess_commit_ctrl_pkg::*;
#(
    parameter int unsigned PINS_MAX = max_pins_count,
    parameter int unsigned COLOR_W  = PIN_COLOR_W,
    parameter int unsigned POS_W    = PIN_POS_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  scan_phase_t                 phase,
    input  logic                        step,
    input  logic [POS_W-1:0]            n,
    input  logic [PINS_MAX*COLOR_W-1:0] guess,
    input  logic [PINS_MAX*COLOR_W-1:0] secret,
    output logic [POS_W-1:0]            pin_idx,
    output logic [COLOR_W-1:0]          cur_pin_c,
    output logic [POS_W-1:0]            green,
    output logic [POS_W-1:0]            yellow,
    output logic                        last_c
);

    logic [COLOR_W-1:0]  g_arr [PINS_MAX];
    logic [COLOR_W-1:0]  s_arr [PINS_MAX];
    logic [POS_W-1:0]    j_idx;
    logic [PINS_MAX-1:0] analyzed_guess;
    logic [PINS_MAX-1:0] analyzed_secret;
    logic [POS_W-1:0]    last_n;
    logic                i_adv;
    logic                j_adv;
    logic                grn_hit;
    logic                yel_hit;

    always_comb begin
        for (int k = 0; k < int'(PINS_MAX); k++) begin
            g_arr[k] = guess[k*COLOR_W +: COLOR_W];
            s_arr[k] = secret[k*COLOR_W +: COLOR_W];
        end
    end

    assign last_n    = n - POS_W'(1);
    assign cur_pin_c = g_arr[pin_idx];

    // One comparison per step; j only walks while guess pin i is still unresolved.
    always_comb begin
        i_adv   = 1'b0;
        j_adv   = 1'b0;
        grn_hit = 1'b0;
        yel_hit = 1'b0;
        case (phase)
            SCAN_GREEN: begin
                i_adv   = step;
                grn_hit = step && (g_arr[pin_idx] == s_arr[pin_idx]);
            end
            SCAN_YELLOW: begin
                if (step) begin
                    if (analyzed_guess[pin_idx]) begin
                        i_adv = 1'b1;
                    end else if ((g_arr[pin_idx] == s_arr[j_idx]) && !analyzed_secret[j_idx]) begin
                        yel_hit = 1'b1;
                        i_adv   = 1'b1;
                    end else if (j_idx == last_n) begin
                        i_adv = 1'b1;
                    end else begin
                        j_adv = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        last_c = i_adv && (pin_idx == last_n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pin_idx         <= '0;
            j_idx           <= '0;
            green           <= '0;
            yellow          <= '0;
            analyzed_guess  <= '0;
            analyzed_secret <= '0;
        end else if (clear) begin
            pin_idx         <= '0;
            j_idx           <= '0;
            green           <= '0;
            yellow          <= '0;
            analyzed_guess  <= '0;
            analyzed_secret <= '0;
        end else begin
            if (i_adv) begin
                pin_idx <= last_c ? '0 : pin_idx + POS_W'(1);
                j_idx   <= '0;
            end else if (j_adv) begin
                j_idx <= j_idx + POS_W'(1);
            end
            if (grn_hit) begin
                analyzed_guess[pin_idx]  <= 1'b1;
                analyzed_secret[pin_idx] <= 1'b1;
                green                    <= green + POS_W'(1);
            end
            if (yel_hit) begin
                analyzed_secret[j_idx] <= 1'b1;
                yellow                 <= yellow + POS_W'(1);
            end
        end
    end

endmodule

// File: rtl/guess_commit_ctrl.sv
// Commits one guess: writes its pins to board RAM, scores it, then writes both hint counts.
module guess_commit_ctrl
    import guess_commit_ctrl_pkg::*;
#(
    parameter int unsigned PINS_MAX     = max_pins_count,
    parameter int unsigned GUESSES_MAX  = max_guesses,
    parameter int unsigned COLOR_W      = PIN_COLOR_W,
    parameter int unsigned POS_W        = PIN_POS_W,
    parameter int unsigned ADDR_W       = board_addr_w,
    parameter int unsigned HINTS_OFFSET = ram_hints_offset
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [POS_W-1:0]            pins_count,
    input  logic [7:0]                  guess_idx,
    input  logic [PINS_MAX*COLOR_W-1:0] guess,
    input  logic [PINS_MAX*COLOR_W-1:0] secret,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [POS_W-1:0]            green,
    output logic [POS_W-1:0]            yellow,
    output logic                        solved,
    output logic                        ram_we,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic [COLOR_W-1:0]          ram_wdata
);

    GUESS_COMMIT_STATE           state;
    GUESS_COMMIT_STATE           state_next;
    logic [PINS_MAX*COLOR_W-1:0] guess_q;
    logic [PINS_MAX*COLOR_W-1:0] secret_q;
    logic [POS_W-1:0]            n_q;
    logic [7:0]                  idx_q;
    logic                        start_ok_c;
    logic                        accept_c;
    scan_phase_t                 scan_phase;
    logic                        scan_step;
    logic                        scan_last_c;
    logic [POS_W-1:0]            scan_i;
    logic [COLOR_W-1:0]          cur_pin_c;
    logic [ADDR_W-1:0]           pin_base_c;
    logic [ADDR_W-1:0]           hint_base_c;

    assign start_ok_c = (pins_count != '0)
                     && (pins_count <= POS_W'(PINS_MAX))
                     && (guess_idx < 8'(GUESSES_MAX));
    assign accept_c   = (state == ST_IDLE) && start && start_ok_c;

    assign pin_base_c  = ADDR_W'(idx_q) * ADDR_W'(PINS_MAX);
    assign hint_base_c = ADDR_W'(HINTS_OFFSET) + (ADDR_W'(idx_q) << 1);

    pin_match_scan #(
        .PINS_MAX (PINS_MAX),
        .COLOR_W  (COLOR_W),
        .POS_W    (POS_W)
    ) u_scan (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept_c),
        .phase     (scan_phase),
        .step      (scan_step),
        .n         (n_q),
        .guess     (guess_q),
        .secret    (secret_q),
        .pin_idx   (scan_i),
        .cur_pin_c (cur_pin_c),
        .green     (green),
        .yellow    (yellow),
        .last_c    (scan_last_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Moore decode of the RAM port and status from state plus scan index.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        scan_phase = SCAN_HOLD;
        scan_step  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept_c) state_next = ST_GREEN;
            end
            ST_GREEN: begin
                busy       = 1'b1;
                ram_we     = 1'b1;
                ram_addr   = pin_base_c + ADDR_W'(scan_i);
                ram_wdata  = cur_pin_c;
                scan_phase = SCAN_GREEN;
                scan_step  = 1'b1;
                if (scan_last_c) state_next = ST_YELLOW;
            end
            ST_YELLOW: begin
                busy       = 1'b1;
                scan_phase = SCAN_YELLOW;
                scan_step  = 1'b1;
                if (scan_last_c) state_next = ST_HINT_G;
            end
            ST_HINT_G: begin
                busy       = 1'b1;
                ram_we     = 1'b1;
                ram_addr   = hint_base_c;
                ram_wdata  = COLOR_W'(green);
                state_next = ST_HINT_Y;
            end
            ST_HINT_Y: begin
                busy       = 1'b1;
                ram_we     = 1'b1;
                ram_addr   = hint_base_c + ADDR_W'(1);
                ram_wdata  = COLOR_W'(yellow);
                state_next = ST_DONE;
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture on accept; solved is resolved entering DONE so it is valid during the done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            guess_q  <= '0;
            secret_q <= '0;
            n_q      <= '0;
            idx_q    <= '0;
            err      <= 1'b0;
            solved   <= 1'b0;
        end else begin
            err <= (state == ST_IDLE) && start && !start_ok_c;
            if (accept_c) begin
                guess_q  <= guess;
                secret_q <= secret;
                n_q      <= pins_count;
                idx_q    <= guess_idx;
                solved   <= 1'b0;
            end else if (state == ST_HINT_Y) begin
                solved <= (green == n_q);
            end
        end
    end

endmodule

// File: tb/tb_guess_commit_ctrl.sv
// Directed bench for guess_commit_ctrl: RAM write trace, hint counts, timing and rejects.
module tb_guess_commit_ctrl;

    logic         clk;
    logic         reset;
    logic         start;
    logic [4:0]   pins_count;
    logic [7:0]   guess_idx;
    logic [99:0]  guess;
    logic [99:0]  secret;
    logic         busy;
    logic         done;
    logic         err;
    logic [4:0]   green;
    logic [4:0]   yellow;
    logic         solved;
    logic         ram_we;
    logic [11:0]  ram_addr;
    logic [4:0]   ram_wdata;

    int checks = 0;
    int errors = 0;
    int last_g = 0;
    int last_y = 0;

    guess_commit_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pins_count (pins_count),
        .guess_idx  (guess_idx),
        .guess      (guess),
        .secret     (secret),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .green      (green),
        .yellow     (yellow),
        .solved     (solved),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [99:0] pack4(input int a, input int b, input int c, input int d);
        logic [99:0] v;
        v = '0;
        v[4:0]   = 5'(a);
        v[9:5]   = 5'(b);
        v[14:10] = 5'(c);
        v[19:15] = 5'(d);
        return v;
    endfunction

    // Runs one commit and checks the full write trace, counts and busy length.
    task automatic commit(input string tag, input int n, input int idx,
                          input logic [99:0] g, input logic [99:0] s,
                          input int exp_g, input int exp_y, input int exp_solved,
                          input int exp_busy, input bit poke);
        int cyc;
        int nwr;
        int ndone;
        int nerr;
        int wa[64];
        int wd[64];
        @(negedge clk);
        start = 1'b1; pins_count = 5'(n); guess_idx = 8'(idx); guess = g; secret = s;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; nwr = 0; ndone = 0; nerr = 0;
        while (busy === 1'b1 && cyc < 500) begin
            if (ram_we === 1'b1) begin
                if (nwr < 64) begin
                    wa[nwr] = int'(ram_addr);
                    wd[nwr] = int'(ram_wdata);
                end
                nwr++;
            end
            if (done === 1'b1) begin
                ndone++;
                check({tag, "_green_at_done"}, int'(green), exp_g);
                check({tag, "_yellow_at_done"}, int'(yellow), exp_y);
                check({tag, "_solved_at_done"}, int'(solved), exp_solved);
            end
            if (err === 1'b1) nerr++;
            start = 1'b0;
            if (poke && cyc == 2) begin
                start = 1'b1; pins_count = 5'd3; guess_idx = 8'd1; guess = '0; secret = '0;
            end
            if (poke && cyc == 4) begin
                start = 1'b1; pins_count = 5'd0; guess_idx = 8'd200;
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_busy_cycles"}, cyc, exp_busy);
        check({tag, "_done_pulses"}, ndone, 1);
        check({tag, "_err_while_busy"}, nerr, 0);
        check({tag, "_write_count"}, nwr, n + 2);
        if (nwr == n + 2) begin
            for (int i = 0; i < n; i++) begin
                check({tag, "_pin_addr"}, wa[i], idx * 20 + i);
                check({tag, "_pin_data"}, wd[i], int'(g[i*5 +: 5]));
            end
            check({tag, "_hint_g_addr"}, wa[n], 1980 + 2 * idx);
            check({tag, "_hint_g_data"}, wd[n], exp_g);
            check({tag, "_hint_y_addr"}, wa[n+1], 1981 + 2 * idx);
            check({tag, "_hint_y_data"}, wd[n+1], exp_y);
        end
        check({tag, "_green_held"}, int'(green), exp_g);
        check({tag, "_yellow_held"}, int'(yellow), exp_y);
        check({tag, "_solved_held"}, int'(solved), exp_solved);
        last_g = exp_g;
        last_y = exp_y;
    endtask

    task automatic reject(input string tag, input int n, input int idx);
        @(negedge clk);
        start = 1'b1; pins_count = 5'(n); guess_idx = 8'(idx); guess = pack4(7, 7, 7, 7);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_err"}, int'(err), 1);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_ram_we"}, int'(ram_we), 0);
        @(negedge clk);
        check({tag, "_err_clear"}, int'(err), 0);
        check({tag, "_busy_after"}, int'(busy), 0);
        check({tag, "_green_kept"}, int'(green), last_g);
        check({tag, "_yellow_kept"}, int'(yellow), last_y);
    endtask

    initial begin
        logic [99:0] gb;
        logic [99:0] sb;
        reset = 1'b1; start = 1'b0; pins_count = '0; guess_idx = '0; guess = '0; secret = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_ram_we", int'(ram_we), 0);
        check("rst_green", int'(green), 0);
        check("rst_yellow", int'(yellow), 0);
        check("rst_solved", int'(solved), 0);
        reset = 1'b0;

        commit("exact", 4, 0, pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), 4, 0, 1, 11, 1'b0);

        reject("rej_n0", 0, 0);
        reject("rej_n21", 21, 0);
        reject("rej_idx99", 4, 99);

        commit("perm", 4, 5, pack4(1, 2, 3, 4), pack4(4, 3, 2, 1), 0, 4, 0, 17, 1'b1);
        commit("dups", 4, 2, pack4(1, 1, 2, 2), pack4(1, 2, 1, 3), 1, 2, 0, 17, 1'b0);

        gb = '0;
        for (int k = 0; k < 20; k++) gb[k*5 +: 5] = 5'(k + 1);
        sb = gb;
        sb[4:0] = 5'd2;
        sb[9:5] = 5'd1;
        commit("edge_row", 20, 98, gb, sb, 18, 2, 0, 44, 1'b0);

        // Reset while GREEN is writing pin 2 of row 1.
        @(negedge clk);
        start = 1'b1; pins_count = 5'd4; guess_idx = 8'd1;
        guess = pack4(1, 2, 3, 4); secret = pack4(1, 2, 3, 4);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_ram_we", int'(ram_we), 1);
        check("mid_ram_addr", int'(ram_addr), 22);
        reset = 1'b1;
        #1;
        check("mid_rst_ram_we", int'(ram_we), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_green", int'(green), 0);
        check("mid_rst_addr", int'(ram_addr), 0);
        @(negedge clk);
        reset = 1'b0;
        last_g = 0;
        last_y = 0;
        commit("after_rst", 4, 3, pack4(5, 6, 7, 8), pack4(5, 6, 7, 8), 4, 0, 1, 11, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/guess_commit_ctrl.md
# guess_commit_ctrl

Sequences the commit of one entered guess on the game board. On a start pulse it captures the guess and the secret, then does four things in order: writes the guess pins into board RAM, counts green hints, counts yellow hints, and writes both hint counts into the hint region of board RAM. It sits between the game state machine, which raises `start` when `is_guess_entered`, and the board RAM write port. Its results feed the board fields `calculated_green` and `calculated_yellow`.

## Interface
Parameters:
- `PINS_MAX`, 20: maximum pins per guess (`max_pins_count`).
- `GUESSES_MAX`, 99: maximum guesses (`max_guesses`).
- `COLOR_W`, 5: pin color width (`PIN_COLOR_W`).
- `POS_W`, 5: pin position/count width (`PIN_POS_W`).
- `ADDR_W`, 12: board RAM address width.
- `HINTS_OFFSET`, 1980: base address of the hint region (`ram_hints_offset`).

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to commit a guess.
- `pins_count`  in  POS_W  active pins n; sampled on an accepted start.
- `guess_idx`  in  8  guess row (`guessed_count`); sampled on an accepted start.
- `guess`  in  PINS_MAX*COLOR_W  packed guess, pin i at bits [i*COLOR_W +: COLOR_W].
- `secret`  in  PINS_MAX*COLOR_W  packed secret, same packing as `guess`.
- `busy`  out  1  high from the cycle after an accepted start until DONE has exited.
- `done`  out  1  one-cycle pulse in DONE.
- `err`  out  1  one-cycle pulse when a start is rejected.
- `green`  out  POS_W  green count; held between commits.
- `yellow`  out  POS_W  yellow count; held between commits.
- `solved`  out  1  equals (`green` == n); held between commits.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  ADDR_W  RAM write address.
- `ram_wdata`  out  COLOR_W  RAM write data.

## Operation
- States: IDLE, GREEN, YELLOW, HINT_G, HINT_Y, DONE.
- **IDLE, accepted start**: `start`=1 with 1 ≤ `pins_count` ≤ PINS_MAX and `guess_idx` < GUESSES_MAX.
  - Capture `guess`, `secret`, n and `guess_idx`.
  - Clear `green`, `yellow`, `solved`, `analyzed_guess` and `analyzed_secret` (both PINS_MAX bits).
  - Set i=0 and go to GREEN.
- **IDLE, rejected start**: any other `start`=1 in IDLE pulses `err` on the next cycle; the state stays IDLE.
- **Start outside IDLE**: ignored, with no `err`.
- **GREEN**: one cycle per pin, i = 0..n-1.
  - Write: `ram_we`=1, `ram_addr` = guess_idx*PINS_MAX + i, `ram_wdata` = guess[i].
  - If guess[i] == secret[i]: set both analyzed bits for position i and increment `green`.
  - After i = n-1, go to YELLOW with i=0, j=0.
- **YELLOW**: one comparison per cycle.
  - If analyzed_guess[i] is set: advance i and spend 1 cycle.
  - Otherwise compare guess[i] with secret[j] for j = 0..n-1.
  - A match with analyzed_secret[j] clear sets analyzed_secret[j], increments `yellow`, advances i and resets j=0.
  - When j = n-1 is reached without a match: advance i and reset j=0.
  - An analyzed secret position still costs its cycle.
  - When i would pass n-1, go to HINT_G.
- **HINT_G**: `ram_we`=1, `ram_addr` = HINTS_OFFSET + 2*guess_idx, `ram_wdata` = `green`.
- **HINT_Y**: the same, with address +1 and data `yellow`.
- **DONE**: `done`=1, `solved` is updated; the next state is IDLE.
- **Width rules**:
  - All address arithmetic is ADDR_W wide and unsigned.
  - Maximum pin address 1979; maximum hint address 2177.
  - Counts never exceed n ≤ 20, so there is no overflow.
- **Reset**: asynchronous. The state goes to IDLE and every output is 0, including `ram_we`, mid-operation. Partial RAM writes are not rolled back.

## Timing
- Moore outputs: `ram_*`, `busy` and `done` are decoded from the state and index registers.
- `err` is registered.
- Start is accepted at edge T. GREEN occupies cycles T+1 .. T+n.
- YELLOW lasts Y cycles, where Y is the sum over i of:
  - 1 if pin i is already green;
  - otherwise k+1, where k is the first unanalyzed matching j;
  - otherwise n if there is no match.
- HINT_G, HINT_Y and DONE take 1 cycle each.
- Total `busy` cycles = n + Y + 3.
- `green`, `yellow` and `solved` are valid from the DONE cycle until the next accepted start.

## Structure
- Shared package holds:
  - a state enum typedef `GUESS_COMMIT_STATE`;
  - use of `max_pins_count`, `max_guesses` and `ram_hints_offset`.
- One sub-module, `pin_match_scan`, holds the i/j counters, the analyzed masks and the green/yellow counters. The controller FSM drives its phase-select and step inputs.

## Test plan
- **Exact guess**: n=4, idx=0, guess {1,2,3,4}, secret {1,2,3,4}.
  - Writes to addresses 0..3, then 1980←4 and 1981←0.
  - green=4, yellow=0, solved=1, busy for 11 cycles.
- **Full permutation**: n=4, idx=5, guess {1,2,3,4}, secret {4,3,2,1}.
  - Pin addresses 100..103; hint addresses 1990←0, 1991←4; solved=0.
- **Duplicates**: n=4, guess {1,1,2,2}, secret {1,2,1,3}.
  - green=1, yellow=2, Y=10, busy for 17 cycles.
- **Boundary row**: n=20, idx=98.
  - Pin addresses 1960..1979; hint addresses 2176 and 2177.
- **Rejects**:
  - pins_count=0: `err` pulses, no `ram_we`, busy stays 0.
  - pins_count=21: same as pins_count=0.
  - idx=99: same as pins_count=0.
  - start during busy: ignored, the result is unchanged.
- **Reset mid-operation**: assert `reset` in GREEN at i=2. `ram_we`, `busy` and `done` drop immediately. A following valid start completes normally.
